// File: rtl/pd_pkg.sv
// Shared fetch/decode definitions.
//   NOP_INSN    : canonical RISC-V NOP (addi x0, x0, 0), shown to decode when
//                 nothing valid is queued.
//   fetch_pkt_t : {pc, insn} packet handed from fetch (PD1) to decode (PD2).
package pd_pkg;

  localparam int PKT_AWIDTH = 32;
  localparam int PKT_DWIDTH = 32;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pc;
    logic [PKT_DWIDTH-1:0] insn;
  } fetch_pkt_t;

endpackage

// File: rtl/fifo_storage.sv
// Register array backing the IF/ID queue: DEPTH entries of pkt_t with one
// synchronous write port and one asynchronous read port. Contents have no
// reset; validity is tracked by the owner's pointers and count.
//   clock   : write clock
//   wr_en   : write wr_data into entry wr_addr at the rising edge
//   wr_addr : write index
//   wr_data : packet to store
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
module fifo_storage
  import pd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type pkt_t = fetch_pkt_t
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  pkt_t                     wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output pkt_t                     rd_data
);

  pkt_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch (PD1) and decode (PD2). Buffers {pc, insn}
// packets under valid/ready so a decode stall never needs a combinational
// path back into fetch. A redirect flush discards everything queued; an
// empty queue presents a NOP to decode.
//   clock     : design clock, rising edge
//   reset     : synchronous, active-low
//   flush     : discard all entries at the next edge (wins over push/pop)
//   in_valid  : fetch presents {in_pc, in_insn}
//   in_ready  : queue has room (independent of out_ready)
//   out_valid : head packet valid
//   out_ready : decode consumes the head this cycle
//   out_pc    : head PC, 0 when empty
//   out_insn  : head instruction, NOP when empty
//   count     : occupancy 0..DEPTH
module if_id_queue
  import pd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AWIDTH-1:0]        in_pc,
  input  logic [DWIDTH-1:0]        in_insn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AWIDTH-1:0]        out_pc,
  output logic [DWIDTH-1:0]        out_insn,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fetch_pkt_t    wr_pkt, rd_pkt;

  // Ready depends only on local state and reset, never on out_ready.
  assign in_ready  = (count_q < CW'(DEPTH)) & reset;
  assign out_valid = (count_q != '0) & reset;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign wr_pkt.pc   = in_pc;
  assign wr_pkt.insn = in_insn;

  assign out_pc   = out_valid ? rd_pkt.pc   : '0;
  assign out_insn = out_valid ? rd_pkt.insn : DWIDTH'(NOP_INSN);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer wrap is the natural binary rollover.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push coinciding with flush is dropped, so it must not touch storage.
  fifo_storage #(
    .DEPTH (DEPTH),
    .pkt_t (fetch_pkt_t)
  ) u_storage (
    .clock   (clock),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_pkt),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_pkt)
  );

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage (PD1: PC + instruction memory) and the decode stage (PD2).
- Buffers {pc, insn} packets under a valid/ready handshake, so decode stalls do not need a combinational path back into fetch.
- Discards all buffered instructions on a redirect flush (branch or jump resolved downstream).
- Presents a canonical NOP to decode whenever it is empty.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- AWIDTH, 32, PC width in bits.
- DWIDTH, 32, instruction width in bits.

Ports:
- clock      input   1                   single design clock; all state updates on rising edge.
- reset      input   1                   synchronous, active-low; queue held in reset while reset==0.
- flush      input   1                   redirect; discard all entries at next edge.
- in_valid   input   1                   fetch presents a packet.
- in_ready   output  1                   queue can accept a packet this cycle.
- in_pc      input   AWIDTH              PC of fetched instruction.
- in_insn    input   DWIDTH              fetched instruction word.
- out_valid  output  1                   head packet valid to decode.
- out_ready  input   1                   decode consumes head this cycle.
- out_pc     output  AWIDTH              head PC.
- out_insn   output  DWIDTH              head instruction, or NOP when empty.
- count      output  $clog2(DEPTH)+1     current occupancy, 0..DEPTH.

Behaviour:
- Reset
  - Sampled only on a rising clock edge with reset==0.
  - Clears wr_ptr, rd_ptr and count to 0.
  - Storage contents are not cleared.
  - While reset==0: in_ready=0, out_valid=0, out_insn=32'h00000013 (NOP), out_pc=0.
- Handshakes
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count < DEPTH) & reset; no dependence on out_ready (no combinational ready path).
  - out_valid = (count != 0).
  - out_pc and out_insn are driven from storage[rd_ptr] when out_valid=1; otherwise out_insn=NOP and out_pc=0.
- Latency: a packet pushed at edge N is visible on out_* after edge N (1 cycle). No same-cycle bypass.
- Pointer and occupancy updates
  - Push writes storage[wr_ptr] and increments wr_ptr modulo DEPTH.
  - Pop increments rd_ptr modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on push & pop.
- Full: in_ready=0. A simultaneous pop frees the slot for the *next* cycle only; a push attempt while full is ignored.
- Empty: out_valid=0; out_ready is ignored.
  - Simultaneous push on empty: count becomes 1 and out_valid=1 next cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Order is strictly FIFO.
- Flush (priority over push and pop)
  - At the edge where flush=1: wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle push is dropped; a same-cycle pop is a no-op.
  - Next cycle: out_valid=0 and out_insn=NOP.
  - in_ready stays 1 during flush (count < DEPTH), so fetch may present the redirected PC in the following cycle.
- Reset mid-operation: identical to flush plus in_ready=0 for the cycle(s) reset==0. Entries in flight are lost.
- Inputs are sampled only at the rising edge; in_pc and in_insn are don't-care when in_valid=0.

Decomposition:
- Shared package pd_pkg holds:
  - NOP_INSN = 32'h00000013.
  - Typedef fetch_pkt_t {logic [AWIDTH-1:0] pc; logic [DWIDTH-1:0] insn;}, reused by the fetch and decode stages.
- Optional sub-module: fifo_storage (DEPTH x fetch_pkt_t register array with one write port and async read). Pointers, count and flush logic stay in if_id_queue.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release
  -> in_ready=0 during reset and 1 after; out_valid=0, out_insn=32'h00000013, count=0.
- Fill and drain with out_ready=0: push pc 0x0, 0x4, 0x8, 0xC with insns 0x00500093, 0x00A00113, 0x002081B3, 0x00000013
  -> count=4 and in_ready=0 after the 4th push; a 5th push at pc 0x10 is ignored.
  - Then set out_ready=1 -> the four packets emerge in order over 4 cycles, then out_valid=0.
- Steady streaming: in_valid=1 and out_ready=1 for 10 cycles, pc incrementing by 4 from 0x100
  -> count stays 1 after the first push; each pc appears exactly once, 1 cycle after its push; pointers wrap twice with no gap.
- Full with simultaneous pop: queue full, pop and attempt push in the same cycle
  -> count=3 and the push is not accepted; next cycle the push is accepted and count=4.
- Flush with concurrent push: 3 entries queued, flush=1 with in_valid=1 at pc 0x200
  -> next cycle count=0, out_valid=0, out_insn=NOP; pc 0x200 never appears.
  - Then push pc 0x80 -> out_pc=0x80 one cycle later.
- Mid-stream reset: 2 entries queued, reset=0 for 1 cycle
  -> count=0, out_valid=0; after release, the first new push emerges correctly with no stale data.
